// File: rtl/one_hot_to_binary_pipe.sv
// Two-stage valid/ready pipeline that turns a one-hot code into its bit index.
// It flags inputs that are not strictly one-hot and keeps a saturating count of errored outputs.
module one_hot_to_binary_pipe #(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 clr_cnt_i,
  output logic [7:0]           err_cnt_o
);

  logic [ONE_HOT_W-1:0] one_hot_p1;
  logic                 vld_p1;
  logic [BIN_W-1:0]     bin_p2;
  logic                 err_p2;
  logic                 vld_p2;
  logic [7:0]           err_cnt;
  logic                 ready_p1;
  logic                 ready_p2;
  logic [BIN_W-1:0]     bin_enc;
  logic                 err_enc;

  // Scanning from the top down leaves the lowest set bit's index, so
  // multi-bit inputs resolve to their least significant set bit.
  function automatic logic [BIN_W-1:0] lowest_index(input logic [ONE_HOT_W-1:0] v);
    logic [BIN_W-1:0] idx;
    idx = '0;
    for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
      if (v[i]) idx = BIN_W'(i);
    end
    return idx;
  endfunction

  function automatic logic not_one_hot(input logic [ONE_HOT_W-1:0] v);
    return (v == '0) || ((v & (v - ONE_HOT_W'(1))) != '0);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign ready_p2   = !vld_p2 || out_ready_i;
  assign ready_p1   = !vld_p1 || ready_p2;
  assign in_ready_o = ready_p1;

  assign bin_enc = lowest_index(one_hot_p1);
  assign err_enc = not_one_hot(one_hot_p1);

  // ---- stage 1: capture raw one-hot input ----
  always_ff @(posedge clk) begin
    if (ready_p1 && in_valid_i) one_hot_p1 <= one_hot_i;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else if (ready_p1) vld_p1 <= in_valid_i;
  end

  // ---- stage 2: encoded index, error flag, output valid ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      bin_p2 <= '0;
      err_p2 <= 1'b0;
    end else if (ready_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        bin_p2 <= bin_enc;
        err_p2 <= err_enc;
      end
    end
  end

  // Clear takes precedence over a same-cycle errored transfer.
  always_ff @(posedge clk) begin
    if (reset) err_cnt <= 8'd0;
    else if (clr_cnt_i) err_cnt <= 8'd0;
    else if (vld_p2 && out_ready_i && err_p2) err_cnt <= sat_inc(err_cnt);
  end

  assign bin_o       = bin_p2;
  assign err_o       = err_p2;
  assign out_valid_o = vld_p2;
  assign err_cnt_o   = err_cnt;

endmodule
